// File: rtl/rs485_slave_responder_if.sv
// rs485_slave_responder_if
// Bus bundle between an RS485 slave responder and its environment.
//   rx          receive line (idle high), driven by the bus side
//   tx_data     response payload, byte 0 in bits [7:0]
//   tx / tx_en  transmit line and RS485 driver enable
//   tx_busy     response in progress
//   tx_done     one-cycle pulse at response completion
//   addr_match  one-cycle pulse on a matching address frame
//   rx_err      one-cycle pulse on a framing/parity error
// Modports: master = environment side, slave = responder side.
interface rs485_slave_responder_if #(
    parameter int NUM_BYTES = 2
);
    logic                   rx;
    logic [8*NUM_BYTES-1:0] tx_data;
    logic                   tx;
    logic                   tx_en;
    logic                   tx_busy;
    logic                   tx_done;
    logic                   addr_match;
    logic                   rx_err;

    modport master (
        output rx, tx_data,
        input  tx, tx_en, tx_busy, tx_done, addr_match, rx_err
    );

    modport slave (
        input  rx, tx_data,
        output tx, tx_en, tx_busy, tx_done, addr_match, rx_err
    );
endinterface

// File: rtl/rs485_slave_responder.sv
// rs485_slave_responder
// Half-duplex RS485 slave: receives 11-bit address frames (start, d0..d7,
// bit9, stop; LSB first), and on a match to SLAVE_ADDR drives the bus and
// returns NUM_BYTES payload frames framed by GUARD_BITS idle-high bit times.
// Optional feature macro: RS485_PARITY_EN (bit9 = even parity, checked on RX;
// otherwise bit9 is sent as 0 and ignored on receive).
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    rs485_slave_responder_if.slave (rx, tx_data, tx, tx_en, tx_busy,
//          tx_done, addr_match, rx_err)
module rs485_slave_responder #(
    parameter int         CLK_DIV    = 50,
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         NUM_BYTES  = 2,
    parameter int         GUARD_BITS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    rs485_slave_responder_if.slave bus
);

`ifdef RS485_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int TW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;
    localparam int BYW  = $clog2(NUM_BYTES + 1);
    localparam int GW   = (GUARD_BITS > 0) ? $clog2(GUARD_BITS + 1) : 1;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_BIT9, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_GUARD_PRE, T_FRAME, T_GUARD_POST} tx_state_t;

    rx_state_t              r_state;
    tx_state_t              t_state;

    logic                   rx_s1, rx_s2, rx_prev;
    logic [TW-1:0]          r_timer;
    logic [2:0]             r_bit;
    logic [7:0]             r_data;
    logic                   r_par;

    logic [TW-1:0]          t_timer;
    logic [3:0]             t_bit;
    logic [BYW-1:0]         t_byte;
    logic [GW-1:0]          t_guard;
    logic [8*NUM_BYTES-1:0] shadow;

    logic [7:0]             cur_byte;
    logic [10:0]            cur_frame;
    logic [3:0]             t_bit_nxt;
    logic                   next_tx;

    function automatic logic bit9_of(input logic [7:0] d);
        return PARITY_EN ? ^d : 1'b0;
    endfunction

    always_comb begin
        cur_byte  = shadow[8*int'(t_byte) +: 8];
        cur_frame = {1'b1, bit9_of(cur_byte), cur_byte, 1'b0};
        t_bit_nxt = t_bit + 4'd1;
        next_tx   = 1'b1;
        if (t_bit_nxt <= 4'd10)
            next_tx = cur_frame[t_bit_nxt];
    end

    // Both FSMs live in one block: a valid address frame in the RX FSM
    // launches the TX FSM in the same edge. The RX section is placed after
    // the TX section so its launch assignments take precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_prev        <= 1'b1;
            r_state        <= R_IDLE;
            r_timer        <= '0;
            r_bit          <= '0;
            r_data         <= '0;
            r_par          <= 1'b0;
            t_state        <= T_IDLE;
            t_timer        <= '0;
            t_bit          <= '0;
            t_byte         <= '0;
            t_guard        <= '0;
            shadow         <= '0;
            bus.tx         <= 1'b1;
            bus.tx_en      <= 1'b0;
            bus.tx_busy    <= 1'b0;
            bus.tx_done    <= 1'b0;
            bus.addr_match <= 1'b0;
            bus.rx_err     <= 1'b0;
        end else begin
            rx_s1          <= bus.rx;
            rx_s2          <= rx_s1;
            rx_prev        <= rx_s2;
            bus.tx_done    <= 1'b0;
            bus.addr_match <= 1'b0;
            bus.rx_err     <= 1'b0;

            // ---------------- transmit ----------------
            case (t_state)
                T_GUARD_PRE: begin
                    if (t_timer == TW'(CLK_DIV - 1)) begin
                        t_timer <= '0;
                        if (t_guard == GW'(GUARD_BITS - 1)) begin
                            t_state <= T_FRAME;
                            t_bit   <= '0;
                            t_byte  <= '0;
                            bus.tx  <= 1'b0;
                        end else begin
                            t_guard <= t_guard + 1'b1;
                        end
                    end else begin
                        t_timer <= t_timer + 1'b1;
                    end
                end
                T_FRAME: begin
                    if (t_timer == TW'(CLK_DIV - 1)) begin
                        t_timer <= '0;
                        if (t_bit == 4'd10) begin
                            if (t_byte == BYW'(NUM_BYTES - 1)) begin
                                bus.tx <= 1'b1;
                                if (GUARD_BITS == 0) begin
                                    t_state     <= T_IDLE;
                                    bus.tx_en   <= 1'b0;
                                    bus.tx_busy <= 1'b0;
                                    bus.tx_done <= 1'b1;
                                end else begin
                                    t_state <= T_GUARD_POST;
                                    t_guard <= '0;
                                end
                            end else begin
                                t_byte <= t_byte + 1'b1;
                                t_bit  <= '0;
                                bus.tx <= 1'b0;
                            end
                        end else begin
                            t_bit  <= t_bit_nxt;
                            bus.tx <= next_tx;
                        end
                    end else begin
                        t_timer <= t_timer + 1'b1;
                    end
                end
                T_GUARD_POST: begin
                    if (t_timer == TW'(CLK_DIV - 1)) begin
                        t_timer <= '0;
                        if (t_guard == GW'(GUARD_BITS - 1)) begin
                            t_state     <= T_IDLE;
                            bus.tx      <= 1'b1;
                            bus.tx_en   <= 1'b0;
                            bus.tx_busy <= 1'b0;
                            bus.tx_done <= 1'b1;
                        end else begin
                            t_guard <= t_guard + 1'b1;
                        end
                    end else begin
                        t_timer <= t_timer + 1'b1;
                    end
                end
                default: ;
            endcase

            // ---------------- receive ----------------
            // Held idle while responding; an edge arriving in the cycle the
            // response ends is lost because tx_busy is still set here.
            if (bus.tx_busy) begin
                r_state <= R_IDLE;
                r_timer <= '0;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        if (rx_prev && !rx_s2) begin
                            r_state <= R_START;
                            r_timer <= '0;
                        end
                    end
                    R_START: begin
                        if (r_timer == TW'(HALF - 1)) begin
                            r_timer <= '0;
                            if (rx_s2) begin
                                r_state <= R_IDLE;
                            end else begin
                                r_state <= R_DATA;
                                r_bit   <= '0;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (r_timer == TW'(CLK_DIV - 1)) begin
                            r_timer <= '0;
                            r_data  <= {rx_s2, r_data[7:1]};
                            if (r_bit == 3'd7)
                                r_state <= R_BIT9;
                            else
                                r_bit <= r_bit + 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    R_BIT9: begin
                        if (r_timer == TW'(CLK_DIV - 1)) begin
                            r_timer <= '0;
                            r_par   <= rx_s2;
                            r_state <= R_STOP;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (r_timer == TW'(CLK_DIV - 1)) begin
                            r_timer <= '0;
                            r_state <= R_IDLE;
                            if (!rx_s2) begin
                                bus.rx_err <= 1'b1;
                            end else if (PARITY_EN && (r_par != ^r_data)) begin
                                bus.rx_err <= 1'b1;
                            end else if (r_data == SLAVE_ADDR && t_state == T_IDLE) begin
                                bus.addr_match <= 1'b1;
                                shadow         <= bus.tx_data;
                                bus.tx_en      <= 1'b1;
                                bus.tx_busy    <= 1'b1;
                                t_timer        <= '0;
                                t_guard        <= '0;
                                t_bit          <= '0;
                                t_byte         <= '0;
                                if (GUARD_BITS == 0) begin
                                    t_state <= T_FRAME;
                                    bus.tx  <= 1'b0;
                                end else begin
                                    t_state <= T_GUARD_PRE;
                                    bus.tx  <= 1'b1;
                                end
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rs485_slave_responder.sv
// tb_rs485_slave_responder
// Directed bench for rs485_slave_responder (CLK_DIV=8, SLAVE_ADDR=01,
// NUM_BYTES=2, GUARD_BITS=1). A timeline model predicts every output each
// cycle from the stimulus schedule; literal frame/length expectations pin it.
// Optional feature macro: RS485_PARITY_EN.
module tb_rs485_slave_responder;

    localparam int         CLK_DIV    = 8;
    localparam logic [7:0] ADDR       = 8'h01;
    localparam int         NUM_BYTES  = 2;
    localparam int         GUARD_BITS = 1;
    localparam int         RESP       = (2*GUARD_BITS + 11*NUM_BYTES) * CLK_DIV;
    // edges from the first edge that sees rx low to the stop-bit sample:
    // 2 sync stages, half a bit to mid-start, then 10 bit periods
    localparam int         LAT        = 2 + CLK_DIV/2 + 10*CLK_DIV;

`ifdef RS485_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    rs485_slave_responder_if #(.NUM_BYTES(NUM_BYTES)) bus ();

    rs485_slave_responder #(
        .CLK_DIV    (CLK_DIV),
        .SLAVE_ADDR (ADDR),
        .NUM_BYTES  (NUM_BYTES),
        .GUARD_BITS (GUARD_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model state: rs = edge after which addr_match is high and the response
    // starts; err_at = edge after which rx_err is high
    int          rs = -1;
    int          err_at = -1;
    logic [15:0] resp_data;
    logic [10:0] cap [NUM_BYTES];
    int          en_cnt, match_cnt, done_cnt, err_cnt;

    function automatic logic bit9_of(input logic [7:0] d);
        return PARITY_EN ? ^d : 1'b0;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, bit9_of(d), d, 1'b0};
    endfunction

    function automatic logic exp_tx(input int j);
        int          b, f;
        logic [10:0] fr;
        logic [7:0]  d;
        b = j / CLK_DIV;
        if (b < GUARD_BITS || b >= GUARD_BITS + 11*NUM_BYTES) return 1'b1;
        f  = b - GUARD_BITS;
        d  = resp_data[8*(f/11) +: 8];
        fr = frame_of(d);
        return fr[f%11];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        int   j, b, f;
        logic e_en, e_tx, e_m, e_d, e_err;
        if (!reset) begin
            j     = cyc - rs;
            e_en  = (rs >= 0) && (j >= 0) && (j < RESP);
            e_tx  = e_en ? exp_tx(j) : 1'b1;
            e_m   = (rs >= 0) && (j == 0);
            e_d   = (rs >= 0) && (j == RESP);
            e_err = (cyc == err_at);
            chk("tx",         32'(bus.tx),         32'(e_tx));
            chk("tx_en",      32'(bus.tx_en),      32'(e_en));
            chk("tx_busy",    32'(bus.tx_busy),    32'(e_en));
            chk("tx_done",    32'(bus.tx_done),    32'(e_d));
            chk("addr_match", 32'(bus.addr_match), 32'(e_m));
            chk("rx_err",     32'(bus.rx_err),     32'(e_err));
            if (bus.tx_en)      en_cnt++;
            if (bus.addr_match) match_cnt++;
            if (bus.tx_done)    done_cnt++;
            if (bus.rx_err)     err_cnt++;
            if (e_en && (j % CLK_DIV) == CLK_DIV/2) begin
                b = j / CLK_DIV;
                if (b >= GUARD_BITS && b < GUARD_BITS + 11*NUM_BYTES) begin
                    f = b - GUARD_BITS;
                    cap[f/11][f%11] = bus.tx;
                end
            end
        end
    end

    task automatic clear_counts();
        en_cnt = 0; match_cnt = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < NUM_BYTES; i++) cap[i] = '0;
    endtask

    // kind: 0 = no reaction, 1 = answered, 2 = rx_err
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stp, input int kind);
        logic [10:0] f;
        f = {stp, b9, d, 1'b0};
        @(posedge clk); #1;
        if (kind == 1) begin
            resp_data = bus.tx_data;
            rs        = cyc + 1 + LAT;
        end else if (kind == 2) begin
            err_at = cyc + 1 + LAT;
        end
        for (int i = 0; i < 11; i++) begin
            bus.rx = f[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        bus.rx = 1'b1;
    endtask

    task automatic scen_end(input string name, input int m, input int d, input int e, input int en);
        chk({name, "_match_cnt"}, 32'(match_cnt), 32'(m));
        chk({name, "_done_cnt"},  32'(done_cnt),  32'(d));
        chk({name, "_err_cnt"},   32'(err_cnt),   32'(e));
        chk({name, "_en_cycles"}, 32'(en_cnt),    32'(en));
    endtask

    initial begin
        reset       = 1'b1;
        bus.rx      = 1'b1;
        bus.tx_data = 16'hA55A;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",         32'(bus.tx),         32'h1);
        chk("rst_tx_en",      32'(bus.tx_en),      32'h0);
        chk("rst_tx_busy",    32'(bus.tx_busy),    32'h0);
        chk("rst_tx_done",    32'(bus.tx_done),    32'h0);
        chk("rst_addr_match", 32'(bus.addr_match), 32'h0);
        chk("rst_rx_err",     32'(bus.rx_err),     32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // match; payload changed right after capture must not leak in
        clear_counts();
        send_frame(ADDR, bit9_of(ADDR), 1'b1, 1);
        bus.tx_data = 16'hFFFF;
        repeat (RESP + 10) @(posedge clk);
        scen_end("match", 1, 1, 0, 192);
        chk("match_frame0", 32'(cap[0]), 32'h4B4);
        chk("match_frame1", 32'(cap[1]), 32'h54A);
        bus.tx_data = 16'hA55A;

        // mismatch
        clear_counts();
        send_frame(8'h02, bit9_of(8'h02), 1'b1, 0);
        repeat (20) @(posedge clk);
        scen_end("mismatch", 0, 0, 0, 0);

        // stop-bit error
        clear_counts();
        send_frame(ADDR, bit9_of(ADDR), 1'b0, 2);
        repeat (20) @(posedge clk);
        scen_end("stoperr", 0, 0, 1, 0);

        // start glitch then a valid frame
        clear_counts();
        @(posedge clk); #1;
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (20) @(posedge clk);
        scen_end("glitch", 0, 0, 0, 0);
        clear_counts();
        send_frame(ADDR, bit9_of(ADDR), 1'b1, 1);
        repeat (RESP + 10) @(posedge clk);
        scen_end("postglitch", 1, 1, 0, 192);

        // reset 50 cycles into the response
        clear_counts();
        send_frame(ADDR, bit9_of(ADDR), 1'b1, 1);
        while (cyc < rs + 50) @(posedge clk);
        #1;
        chk("pre_rst_tx_en", 32'(bus.tx_en), 32'h1);
        reset = 1'b1;
        rs    = -1;
        #1;
        chk("midrst_tx_en",   32'(bus.tx_en),   32'h0);
        chk("midrst_tx",      32'(bus.tx),      32'h1);
        chk("midrst_tx_busy", 32'(bus.tx_busy), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (RESP) @(posedge clk);
        chk("midrst_done_cnt", 32'(done_cnt), 32'h0);
        clear_counts();
        send_frame(ADDR, bit9_of(ADDR), 1'b1, 1);
        repeat (RESP + 10) @(posedge clk);
        scen_end("afterrst", 1, 1, 0, 192);
        chk("afterrst_frame0", 32'(cap[0]), 32'h4B4);

`ifdef RS485_PARITY_EN
        clear_counts();
        bus.tx_data = 16'h0307;
        send_frame(ADDR, 1'b1, 1'b1, 1);
        repeat (RESP + 10) @(posedge clk);
        scen_end("par", 1, 1, 0, 192);
        chk("par_frame0", 32'(cap[0]), 32'h60E);
        chk("par_frame1", 32'(cap[1]), 32'h406);
        clear_counts();
        send_frame(ADDR, 1'b0, 1'b1, 2);
        repeat (20) @(posedge clk);
        scen_end("parerr", 0, 0, 1, 0);
`else
        // bit9 is ignored: a set bit9 still gets an answer
        clear_counts();
        bus.tx_data = 16'h0307;
        send_frame(ADDR, 1'b1, 1'b1, 1);
        repeat (RESP + 10) @(posedge clk);
        scen_end("bit9ign", 1, 1, 0, 192);
        chk("bit9ign_frame0", 32'(cap[0]), 32'h40E);
        chk("bit9ign_frame1", 32'(cap[1]), 32'h406);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
